// File: rtl/key_event_scheduler.sv
// Debounces four push-buttons, classifies press/hold and serves events to an atomic test-and-clear port (`KEY_AUTOREPEAT_EN` adds hold auto-repeat).
// Latency: key_down changes DEBOUNCE_CYCLES+2 edges after a raw edge; ATC response one cycle after atc_req.
// Backpressure: none; one ATC request accepted per cycle, events coalesce into set flags and raise lost.
module key_event_scheduler #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CW              = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    input  logic       atc_req,
    input  logic [2:0] atc_bit,
    output logic       atc_valid,
    output logic       atc_hit,
    output logic [7:0] events,
    output logic [3:0] key_down,
    output logic       lost
);
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} cls_state_t;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rep_cnt [4];
`endif

    logic [3:0]    sync1, sync2, sample;
    logic [CW-1:0] db_cnt [4];
    logic [CW-1:0] hold_cnt [4];
    cls_state_t    state [4];
    logic [3:0]    press_set, hold_set;
    logic [7:0]    ev_set, ev_clr;

    assign sample = ~sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            key_down <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sample[i] == key_down[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    key_down[i] <= ~key_down[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A release on the last hold count still counts as a press: falling edge has priority.
    always_comb begin
        press_set = '0;
        hold_set  = '0;
        for (int i = 0; i < 4; i++) begin
            case (state[i])
                PRESSED: begin
                    if (!key_down[i])
                        press_set[i] = 1'b1;
                    else if (hold_cnt[i] == HOLD_LAST)
                        hold_set[i] = 1'b1;
                end
`ifdef KEY_AUTOREPEAT_EN
                HELD: begin
                    if (key_down[i] && rep_cnt[i] == REP_LAST)
                        hold_set[i] = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state[i]    <= IDLE;
                hold_cnt[i] <= '0;
`ifdef KEY_AUTOREPEAT_EN
                rep_cnt[i]  <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    IDLE: begin
                        if (key_down[i]) begin
                            state[i]    <= PRESSED;
                            hold_cnt[i] <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!key_down[i]) begin
                            state[i] <= IDLE;
                        end else if (hold_cnt[i] == HOLD_LAST) begin
                            state[i] <= HELD;
`ifdef KEY_AUTOREPEAT_EN
                            rep_cnt[i] <= '0;
`endif
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!key_down[i]) begin
                            state[i] <= IDLE;
`ifdef KEY_AUTOREPEAT_EN
                        end else if (rep_cnt[i] == REP_LAST) begin
                            rep_cnt[i] <= '0;
                        end else begin
                            rep_cnt[i] <= rep_cnt[i] + 1'b1;
`endif
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    assign ev_set = {hold_set, press_set};
    assign ev_clr = atc_req ? (8'd1 << atc_bit) : 8'd0;

    // Clear before set, so a colliding event survives while the response reports the old flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            events    <= '0;
            atc_valid <= 1'b0;
            atc_hit   <= 1'b0;
            lost      <= 1'b0;
        end else begin
            events    <= (events & ~ev_clr) | ev_set;
            atc_valid <= atc_req;
            atc_hit   <= atc_req & events[atc_bit];
            if (|(ev_set & events & ~ev_clr))
                lost <= 1'b1;
        end
    end
endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with a response scoreboard on the ATC port.
module tb_key_event_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic       atc_req;
    logic [2:0] atc_bit;
    logic       atc_valid;
    logic       atc_hit;
    logic [7:0] events;
    logic [3:0] key_down;
    logic       lost;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       hit;
        logic [7:0] ev;
    } exp_t;
    exp_t exp_q[$];

`ifdef KEY_AUTOREPEAT_EN
    localparam logic EXP_LOST = 1'b1;
`else
    localparam logic EXP_LOST = 1'b0;
`endif

    key_event_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8),
        .CW             (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .atc_req  (atc_req),
        .atc_bit  (atc_bit),
        .atc_valid(atc_valid),
        .atc_hit  (atc_hit),
        .events   (events),
        .key_down (key_down),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and record the response it must produce.
    task automatic atc(input logic [2:0] b, input logic hit, input logic [7:0] ev_after);
        exp_t e;
        e.hit   = hit;
        e.ev    = ev_after;
        exp_q.push_back(e);
        atc_req = 1'b1;
        atc_bit = b;
        tick(1);
        atc_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (atc_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL atc_unexpected: got valid hit=%0d expected no response", atc_hit);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("atc_hit", {7'd0, atc_hit}, {7'd0, e.hit});
                check("atc_events", events, e.ev);
            end
        end
    end

    initial begin
        logic saw_rise;
        rst     = 1'b1;
        key_n   = 4'hF;
        atc_req = 1'b0;
        atc_bit = 3'd0;
        tick(3);
        check("rst_events", events, 8'h00);
        check("rst_key_down", {4'd0, key_down}, 8'h00);
        check("rst_valid", {7'd0, atc_valid}, 8'h00);
        check("rst_lost", {7'd0, lost}, 8'h00);
        rst = 1'b0;
        tick(10);
        check("idle_key_down", {4'd0, key_down}, 8'h00);

        // Short press on key 2
        key_n[2] = 1'b0;
        tick(5);
        check("s1_kd_early", {4'd0, key_down}, 8'h00);
        tick(1);
        check("s1_kd_rise", {4'd0, key_down}, 8'h04);
        tick(4);
        key_n[2] = 1'b1;
        tick(6);
        check("s1_ev_before", events, 8'h00);
        tick(1);
        check("s1_press", events, 8'h04);
        atc(3'd2, 1'b1, 8'h00);
        atc(3'd2, 1'b0, 8'h00);
        tick(3);

        // Key 0 bouncing every cycle
        saw_rise = 1'b0;
        for (int i = 0; i < 30; i++) begin
            key_n[0] = ~key_n[0];
            tick(1);
            if (key_down[0]) saw_rise = 1'b1;
        end
        key_n[0] = 1'b1;
        tick(10);
        check("s2_no_rise", {7'd0, saw_rise}, 8'h00);
        check("s2_events", events, 8'h00);

        // Long hold on key 3
        key_n[3] = 1'b0;
        tick(26);
        check("s3_pre_hold", events, 8'h00);
        tick(1);
        check("s3_hold", events, 8'h80);
        tick(13);
        key_n[3] = 1'b1;
        tick(10);
        check("s3_no_press", events, 8'h80);
        check("s3_lost", {7'd0, lost}, {7'd0, EXP_LOST});
        atc(3'd7, 1'b1, 8'h00);
        tick(3);

        // Press on key 1 completes on the same edge as its ATC
        key_n[1] = 1'b0;
        tick(10);
        key_n[1] = 1'b1;
        tick(6);
        atc(3'd1, 1'b0, 8'h02);
        tick(1);
        atc(3'd1, 1'b1, 8'h00);
        tick(3);

        // Keys 1 and 2 released together, then back-to-back ATC
        key_n = 4'b1001;
        tick(10);
        key_n = 4'hF;
        tick(7);
        check("s5_events", events, 8'h06);
        atc(3'd1, 1'b1, 8'h04);
        atc(3'd2, 1'b1, 8'h00);
        tick(3);

        // Reset while key 0 is pressed and its hold flag is set
        key_n[0] = 1'b0;
        tick(27);
        check("s6_hold", events, 8'h10);
        tick(3);
        key_n[0] = 1'b1;
        tick(10);
        key_n[0] = 1'b0;
        tick(10);
        check("s6_pre_rst", events, 8'h10);
        rst     = 1'b1;
        atc_req = 1'b1;
        atc_bit = 3'd4;
        tick(1);
        check("s6_rst_events", events, 8'h00);
        check("s6_rst_kd", {4'd0, key_down}, 8'h00);
        check("s6_rst_valid", {7'd0, atc_valid}, 8'h00);
        check("s6_rst_hit", {7'd0, atc_hit}, 8'h00);
        check("s6_rst_lost", {7'd0, lost}, 8'h00);
        rst     = 1'b0;
        atc_req = 1'b0;
        tick(3);
        check("s6_kd_early", {4'd0, key_down}, 8'h00);
        tick(1);
        check("s6_kd_rise", {4'd0, key_down}, 8'h01);
        tick(5);
        key_n[0] = 1'b1;
        tick(6);
        check("s6_ev_before", events, 8'h00);
        tick(1);
        check("s6_press", events, 8'h01);
        atc(3'd0, 1'b1, 8'h00);
        atc(3'd4, 1'b0, 8'h00);
        tick(3);

        check("resp_pending", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
